// File: rtl/sc_lfsr_sng.sv
// Stochastic number generator: XNOR Fibonacci LFSR plus comparator, emitting one
// full LFSR period of a unipolar bitstream for a latched operand and counting its ones.
module sc_lfsr_sng #(
    parameter int                 WIDTH    = 7,
    parameter logic [WIDTH-1:0]   TAP_MASK = 7'b1100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] rn,
    output logic             bit_out,
    output logic             bit_vld,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ones_count,
    output logic             seed_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    // Last count value of a run: L-1 = 2^WIDTH - 2.
    localparam logic [WIDTH-1:0] LAST_CNT = ALL_ONES - 1'b1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rn_q, rn_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ones_q, ones_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_vld_q, bit_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             seed_err_q, seed_err_d;

    logic [WIDTH-1:0] rn_step;
    logic             below;

    assign rn_step = {rn_q[WIDTH-2:0], ~^(rn_q & TAP_MASK)};
    assign below   = (rn_q < val_q);

    always_comb begin
        state_d    = state_q;
        rn_d       = rn_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        bit_out_d  = bit_out_q;
        bit_vld_d  = bit_vld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        seed_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    // All-ones would lock the XNOR LFSR, so substitute zero.
                    if (seed == ALL_ONES) begin
                        rn_d       = '0;
                        seed_err_d = 1'b1;
                    end else begin
                        rn_d = seed;
                    end
                end
                if (start) begin
                    val_d   = value;
                    ones_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                bit_out_d = below;
                bit_vld_d = 1'b1;
                ones_d    = ones_q + WIDTH'(below);
                rn_d      = rn_step;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bit_vld_d = 1'b0;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rn_q       <= '0;
            val_q      <= '0;
            cnt_q      <= '0;
            ones_q     <= '0;
            bit_out_q  <= 1'b0;
            bit_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rn_q       <= rn_d;
            val_q      <= val_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            bit_out_q  <= bit_out_d;
            bit_vld_q  <= bit_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign rn         = rn_q;
    assign bit_out    = bit_out_q;
    assign bit_vld    = bit_vld_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_q;
    assign seed_err   = seed_err_q;

endmodule

// File: tb/tb_sc_lfsr_sng.sv
// Scoreboard bench for sc_lfsr_sng: expected stream bits and run totals are queued
// at start; a negedge monitor checks them whenever the DUT presents bits or done.
module tb_sc_lfsr_sng;

    localparam int W = 7;
    localparam int L = (1 << W) - 1;
    localparam logic [W-1:0] TAPS = 7'b1100000;
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         seed_load = 1'b0;
    logic [W-1:0] seed = '0;
    logic         start = 1'b0;
    logic [W-1:0] value = '0;
    logic [W-1:0] rn;
    logic         bit_out, bit_vld, busy, done, seed_err;
    logic [W-1:0] ones_count;

    int checks = 0;
    int failures = 0;

    logic [W:0]   bit_q[$];   // {expected bit, expected rn after that edge}
    logic [W-1:0] done_q[$];  // expected ones_count per run
    logic [W-1:0] model_rn = '0;
    int           ones_seen = 0;
    int           vld_seen = 0;

    sc_lfsr_sng #(.WIDTH(W), .TAP_MASK(TAPS)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start),
        .value(value), .rn(rn), .bit_out(bit_out), .bit_vld(bit_vld), .busy(busy),
        .done(done), .ones_count(ones_count), .seed_err(seed_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        int par = 0;
        for (int i = 0; i < W; i++) if (TAPS[i] && s[i]) par++;
        return {s[W-2:0], (par % 2 == 0) ? 1'b1 : 1'b0};
    endfunction

    // Monitor: consumes queued expectations as the DUT presents output.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                ones_seen = 0;
                vld_seen  = 0;
            end else begin
                if (bit_vld) begin
                    if (bit_q.size() == 0) begin
                        chk("unexpected_bit_vld", 1, 0);
                    end else begin
                        logic [W:0] e;
                        e = bit_q.pop_front();
                        chk("bit_out", int'(bit_out), int'(e[W]));
                        chk("rn_step", int'(rn), int'(e[W-1:0]));
                        if (rn == ONES) chk("rn_lockup", int'(rn), 0);
                        ones_seen += int'(bit_out);
                        vld_seen++;
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        logic [W-1:0] ev;
                        ev = done_q.pop_front();
                        chk("ones_count", int'(ones_count), int'(ev));
                        chk("bench_ones", ones_seen, int'(ev));
                        chk("vld_cycles", vld_seen, L);
                        chk("bits_left", bit_q.size(), 0);
                    end
                    ones_seen = 0;
                    vld_seen  = 0;
                end
            end
        end
    end

    task automatic load_seed(input logic [W-1:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed = s;
        @(negedge clk);
        seed_load = 1'b0;
        model_rn = (s == ONES) ? '0 : s;
        chk("seed_rn", int'(rn), int'(model_rn));
        chk("seed_err_pulse", int'(seed_err), (s == ONES) ? 1 : 0);
        @(negedge clk);
        chk("seed_err_clear", int'(seed_err), 0);
        $display("seed_load seed=%02h rn=%02h", s, rn);
    endtask

    // One run; ignore_at / reset_at give the cycle index after T0 at which to
    // inject ignored requests or an asynchronous reset (0 = never).
    task automatic run(input logic do_seed, input logic [W-1:0] s, input logic [W-1:0] v,
                       input int ignore_at, input int reset_at);
        logic [W-1:0] st, cur;
        int done_at = -1;
        @(negedge clk);
        start = 1'b1;
        seed_load = do_seed;
        seed = s;
        value = v;
        st = do_seed ? ((s == ONES) ? '0 : s) : model_rn;
        cur = st;
        for (int k = 0; k < L; k++) begin
            logic b;
            b = (cur < v);
            cur = lfsr_next(cur);
            bit_q.push_back({b, cur});
        end
        done_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        seed_load = 1'b0;
        chk("busy_after_T0", int'(busy), 1);
        for (int i = 1; i <= L + 1; i++) begin
            @(negedge clk);
            if (i == reset_at) begin
                #2;
                rst = 1'b0;
                #1;
                chk("rst_rn", int'(rn), 0);
                chk("rst_outs", int'({bit_out, bit_vld, busy, done, seed_err}), 0);
                chk("rst_ones", int'(ones_count), 0);
                bit_q.delete();
                done_q.delete();
                model_rn = '0;
                @(negedge clk);
                rst = 1'b1;
                $display("run value=%0d reset at cycle %0d", v, i);
                return;
            end
            if (start) begin
                start = 1'b0;
                seed_load = 1'b0;
            end
            if (i == ignore_at) begin
                start = 1'b1;
                seed_load = 1'b1;
                seed = W'($urandom);
                value = W'($urandom);
            end
            if (i <= L) chk("busy_run", int'(busy), 1);
            if (done && done_at < 0) done_at = i;
        end
        chk("done_cycle", done_at, L + 1);
        chk("busy_at_done", int'(busy), 0);
        chk("rn_returns", int'(rn), int'(st));
        @(negedge clk);
        chk("done_clear", int'(done), 0);
        chk("ones_hold", int'(ones_count), int'(v));
        model_rn = st;
        $display("run seed=%02h value=%0d ones_count=%0d done_at=%0d", st, v, ones_count, done_at);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_rn", int'(rn), 0);
        chk("reset_outs", int'({bit_out, bit_vld, busy, done, seed_err}), 0);
        chk("reset_ones", int'(ones_count), 0);
        $display("reset released rn=%02h", rn);

        load_seed(7'h01);
        run(1'b0, '0, 7'd0, 0, 0);
        run(1'b1, W'($urandom_range(0, 126)), 7'd1, 0, 0);
        run(1'b1, W'($urandom_range(0, 126)), 7'd64, 0, 0);
        run(1'b1, W'($urandom_range(0, 126)), 7'd100, 0, 0);
        run(1'b1, W'($urandom_range(0, 126)), 7'd127, 0, 0);
        load_seed(7'h7F);
        run(1'b0, '0, 7'd50, 0, 0);
        run(1'b0, '0, W'($urandom), 40, 0);
        run(1'b1, 7'h2A, 7'd10, 0, 0);
        run(1'b1, W'($urandom), W'($urandom), 0, 60);
        run(1'b0, '0, W'($urandom), 0, 0);
        for (int r = 0; r < 4; r++) begin
            run(1'b1, W'($urandom), W'($urandom), 0, 0);
        end

        repeat (2) @(negedge clk);
        chk("queues_drained", bit_q.size() + done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
